cpu_tx_streamer: RTL and testbench

CPU_TX_STREAMER -- requirements
Module: cpu_tx_streamer

---
 rtl/cpu_tx_streamer_pkg.sv | 7 +
 rtl/cpu_tx_streamer_tx_skid_buf.sv | 38 +++
 rtl/cpu_tx_streamer.sv | 98 +++++++++
 tb/tb_cpu_tx_streamer.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/cpu_tx_streamer_pkg.sv
// cpu_tx_streamer_pkg: shared state encoding and default widths for the CPU tx streamer
package cpu_tx_streamer_pkg;
  localparam int DATA_W_DEF = 64;
  localparam int ADDR_W_DEF = 8;
  localparam int PKT_CNT_W = 16;
  typedef enum logic [1:0] {IDLE, STREAM, DONE, WAIT_CLR} tx_state_t;
endpackage

// File: rtl/cpu_tx_streamer_tx_skid_buf.sv
// tx_skid_buf: two-entry valid/ready output buffer that absorbs the buffer read latency
module tx_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [1:0]   level
);
  logic [W-1:0] d0, d1;
  logic push, pop;
  assign in_ready = level != 2'd2;
  assign out_valid = level != 2'd0;
  assign out_data = d0;
  assign push = in_valid && in_ready;
  assign pop = out_valid && out_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      d0 <= '0;
      d1 <= '0;
      level <= 2'd0;
    end else begin
      level <= flush ? 2'd0 : level + 2'(push) - 2'(pop);
      if (pop && level == 2'd2)
        d0 <= d1;
      else if (push && (level == 2'd0 || (level == 2'd1 && pop)))
        d0 <= in_data;
      if (push && level == 2'd1 && !pop)
        d1 <= in_data;
    end
  end
endmodule

// File: rtl/cpu_tx_streamer.sv
// cpu_tx_streamer: streams a CPU tx buffer packet onto a valid/ready/last stream
module cpu_tx_streamer
  import cpu_tx_streamer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                 OPB_Clk,
  input  logic                 OPB_Rst,
  output logic [ADDR_W-1:0]    cpu_tx_buffer_addr,
  input  logic [DATA_W-1:0]    cpu_tx_buffer_rd_data,
  input  logic [ADDR_W-1:0]    cpu_tx_size,
  input  logic                 cpu_tx_ready,
  output logic                 cpu_tx_done,
  input  logic                 soft_reset,
  output logic [DATA_W-1:0]    tx_data,
  output logic                 tx_valid,
  output logic                 tx_last,
  input  logic                 tx_ready,
  output logic                 tx_busy,
  output logic [PKT_CNT_W-1:0] tx_pkt_count
);
  tx_state_t state, state_n;
  logic [ADDR_W-1:0] size_q, rd_ptr, last_addr;
  logic rd_pend, rd_pend_last, issued_all, done_ok;
  logic rd_issue, rd_at_last, room, flush, pop;
  logic sk_in_ready, sk_valid;
  logic [DATA_W:0] sk_data;
  logic [1:0] level;
  assign last_addr = (state == IDLE ? cpu_tx_size : size_q) - ADDR_W'(1);
  assign rd_at_last = rd_ptr == last_addr;
  assign pop = sk_valid && tx_ready;
  assign room = rd_pend ? (level == 2'd0 || (level == 2'd1 && pop)) : (sk_in_ready || pop);
  assign cpu_tx_buffer_addr = rd_ptr;
  assign cpu_tx_done = state == DONE;
  assign tx_busy = state != IDLE;
  assign tx_valid = sk_valid;
  assign tx_data = sk_data[DATA_W-1:0];
  assign tx_last = sk_valid && sk_data[DATA_W];
  tx_skid_buf #(.W(DATA_W + 1)) u_skid (
    .clk(OPB_Clk),
    .rst(OPB_Rst),
    .flush(flush),
    .in_data({rd_pend_last, cpu_tx_buffer_rd_data}),
    .in_valid(rd_pend),
    .in_ready(sk_in_ready),
    .out_data(sk_data),
    .out_valid(sk_valid),
    .out_ready(tx_ready),
    .level(level)
  );
  always_ff @(posedge OPB_Clk) begin
    state <= OPB_Rst ? IDLE : state_n;
  end
  always_comb begin
    state_n = state;
    rd_issue = 1'b0;
    flush = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_tx_ready && !soft_reset) begin
          state_n = cpu_tx_size == '0 ? DONE : STREAM;
          rd_issue = cpu_tx_size != '0;
        end
      end
      STREAM: begin
        if (soft_reset) begin
          state_n = DONE;
          flush = 1'b1;
        end else begin
          rd_issue = !issued_all && room;
          state_n = pop && sk_data[DATA_W] ? DONE : STREAM;
        end
      end
      DONE: state_n = WAIT_CLR;
      default: state_n = cpu_tx_ready ? WAIT_CLR : IDLE;
    endcase
  end
  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      size_q <= '0;
      rd_ptr <= '0;
      rd_pend <= 1'b0;
      rd_pend_last <= 1'b0;
      issued_all <= 1'b0;
      done_ok <= 1'b0;
      tx_pkt_count <= '0;
    end else begin
      size_q <= state == IDLE ? cpu_tx_size : size_q;
      rd_ptr <= rd_issue && !rd_at_last ? rd_ptr + ADDR_W'(1) : (state == STREAM && !soft_reset ? rd_ptr : '0);
      rd_pend <= rd_issue;
      rd_pend_last <= rd_at_last;
      issued_all <= rd_issue ? rd_at_last : (state == STREAM && !soft_reset && issued_all);
      done_ok <= state == STREAM && !soft_reset && pop && sk_data[DATA_W];
      tx_pkt_count <= tx_pkt_count + PKT_CNT_W'(state == DONE && done_ok);
    end
  end
endmodule

// File: tb/tb_cpu_tx_streamer.sv
// tb_cpu_tx_streamer: directed checks of packet streaming, backpressure, abort and reset
module tb_cpu_tx_streamer;
  logic OPB_Clk, OPB_Rst;
  logic [7:0] cpu_tx_buffer_addr, cpu_tx_size;
  logic [63:0] cpu_tx_buffer_rd_data, tx_data;
  logic cpu_tx_ready, cpu_tx_done, soft_reset, tx_valid, tx_last, tx_ready, tx_busy;
  logic [15:0] tx_pkt_count;
  logic [63:0] mem [256];
  int checks = 0;
  int errors = 0;
  cpu_tx_streamer dut (
    .OPB_Clk(OPB_Clk),
    .OPB_Rst(OPB_Rst),
    .cpu_tx_buffer_addr(cpu_tx_buffer_addr),
    .cpu_tx_buffer_rd_data(cpu_tx_buffer_rd_data),
    .cpu_tx_size(cpu_tx_size),
    .cpu_tx_ready(cpu_tx_ready),
    .cpu_tx_done(cpu_tx_done),
    .soft_reset(soft_reset),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_last(tx_last),
    .tx_ready(tx_ready),
    .tx_busy(tx_busy),
    .tx_pkt_count(tx_pkt_count)
  );
  initial OPB_Clk = 1'b0;
  always #5 OPB_Clk = ~OPB_Clk;
  always @(posedge OPB_Clk) cpu_tx_buffer_rd_data <= mem[cpu_tx_buffer_addr];
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic check_zero_outputs(input string tag);
    check({tag, "_addr"}, 64'(cpu_tx_buffer_addr), 64'd0);
    check({tag, "_done"}, 64'(cpu_tx_done), 64'd0);
    check({tag, "_valid"}, 64'(tx_valid), 64'd0);
    check({tag, "_last"}, 64'(tx_last), 64'd0);
    check({tag, "_data"}, tx_data, 64'd0);
    check({tag, "_busy"}, 64'(tx_busy), 64'd0);
    check({tag, "_count"}, 64'(tx_pkt_count), 64'd0);
  endtask
  task automatic send(input int size, input int mode, input int abort_k, input int hold, input int exp_beats, input int exp_cnt);
    logic [63:0] bq[$];
    logic lq[$];
    logic [63:0] pd;
    logic pv, pr, pl;
    int done_cnt, done_k, first_k, last_k, max_addr, vcnt;
    done_cnt = 0; done_k = -1; first_k = -1; last_k = -1; max_addr = 0; vcnt = 0;
    pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0;
    @(posedge OPB_Clk); #1;
    cpu_tx_size = 8'(size);
    cpu_tx_ready = 1'b1;
    tx_ready = 1'b1;
    for (int k = 1; k < 800; k++) begin
      @(posedge OPB_Clk); #1;
      tx_ready = (mode == 0) || (k % 3 == 0);
      soft_reset = (k == abort_k);
      if (done_k >= 0 && k == done_k + hold + 1) cpu_tx_ready = 1'b0;
      @(negedge OPB_Clk);
      if (pv && !pr && abort_k == 0) begin
        check("hold_valid", 64'(tx_valid), 64'd1);
        check("hold_data", tx_data, pd);
        check("hold_last", 64'(tx_last), 64'(pl));
      end
      if (abort_k > 0 && k == abort_k + 1) check("abort_drop", 64'(tx_valid), 64'd0);
      if (done_k >= 0) check("no_restart", 64'(tx_valid), 64'd0);
      if (tx_valid) vcnt++;
      if (tx_valid && tx_ready) begin
        bq.push_back(tx_data);
        lq.push_back(tx_last);
        if (first_k < 0) first_k = k;
        last_k = k;
      end
      if (cpu_tx_done) begin
        done_cnt++;
        if (done_k < 0) done_k = k;
      end
      if (int'(cpu_tx_buffer_addr) > max_addr) max_addr = int'(cpu_tx_buffer_addr);
      pv = tx_valid; pr = tx_ready; pd = tx_data; pl = tx_last;
      if (done_k >= 0 && k == done_k + hold + 4) break;
    end
    cpu_tx_ready = 1'b0;
    soft_reset = 1'b0;
    check("done_cnt", 64'(done_cnt), 64'd1);
    check("beats", 64'(bq.size()), 64'(exp_beats));
    for (int i = 0; i < bq.size() && i < exp_beats; i++) begin
      check("data", bq[i], mem[i]);
      check("last", 64'(lq[i]), 64'(i == size - 1));
    end
    if (mode == 0 && abort_k == 0 && size > 0) begin
      check("first_k", 64'(first_k), 64'd2);
      check("gapless", 64'(last_k - first_k), 64'(size - 1));
      check("done_k", 64'(done_k), 64'(size + 2));
    end
    if (size == 0) begin
      check("done_k0", 64'(done_k), 64'd1);
      check("vcnt0", 64'(vcnt), 64'd0);
    end
    if (abort_k == 0) check("max_addr", 64'(max_addr), 64'(size == 0 ? 0 : size - 1));
    check("pkt_count", 64'(tx_pkt_count), 64'(exp_cnt));
    check("busy_end", 64'(tx_busy), 64'd0);
  endtask
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = {32'hC0DE0000 | 32'(i), ~32'(i * 7)};
    OPB_Rst = 1'b1;
    cpu_tx_size = '0;
    cpu_tx_ready = 1'b0;
    soft_reset = 1'b0;
    tx_ready = 1'b0;
    repeat (3) @(posedge OPB_Clk);
    @(negedge OPB_Clk);
    check_zero_outputs("reset");
    @(posedge OPB_Clk); #1;
    OPB_Rst = 1'b0;
    send(3, 0, 0, 0, 3, 1);
    send(4, 1, 0, 0, 4, 2);
    send(0, 0, 0, 0, 0, 2);
    send(255, 0, 0, 0, 255, 3);
    send(8, 0, 3, 0, 2, 3);
    send(5, 0, 0, 10, 5, 4);
    @(posedge OPB_Clk); #1;
    cpu_tx_size = 8'd8;
    cpu_tx_ready = 1'b1;
    tx_ready = 1'b1;
    repeat (3) @(posedge OPB_Clk);
    #1;
    OPB_Rst = 1'b1;
    cpu_tx_ready = 1'b0;
    @(posedge OPB_Clk); #1;
    OPB_Rst = 1'b0;
    @(negedge OPB_Clk);
    check_zero_outputs("midrst");
    for (int k = 0; k < 4; k++) begin
      @(negedge OPB_Clk);
      check("midrst_nodone", 64'(cpu_tx_done), 64'd0);
      check("midrst_novalid", 64'(tx_valid), 64'd0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
